bsw_max_tracker: RTL and testbench
==================================

Name: bsw_max_tracker

Overview:
Consumer end of the banded Smith-Waterman PE array. Each beat, it receives the H scores from all NPE lanes for one query row. It masks out lanes that fall outside the matrix and tracks the running maximum score and its (i,j) cell. It stops early on X-drop or at the end of the query, then presents the result through a valid/ready handshake to the host/control logic.

Parameters:
NPE, 8, number of PE lanes per beat (band width)
HW, 7, score width; matches the unsigned PE H output
IDXW, 10, width of the query/reference length and position fields
XDROP, 20, early-termination threshold in score units

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse to begin an alignment; honoured only in IDLE
qlen  input  IDXW  query length, latched on start
rlen  input  IDXW  reference length, latched on start
h_valid  input  1  h_vec beat valid
h_vec  input  NPE*HW  lane k occupies bits [k*HW +: HW]; unsigned scores
in_ready  output  1  high only in SCAN; a beat transfers when h_valid && in_ready
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid && res_ready
max_score  output  HW  best score
max_i  output  IDXW  query index of the best cell
max_j  output  IDXW  reference index of the best cell
xdrop_hit  output  1  1 = terminated by X-drop, 0 = full query scanned
busy  output  1  state != IDLE

Behaviour:
- Coordinates: beat t (0-based per alignment), lane k → cell i=t, j=t+k-NPE/2. A lane is valid iff 0<=j<rlen. Invalid lanes are ignored regardless of value.
- FSM states: IDLE, SCAN, FLUSH, RESULT.
  - IDLE: on start, latch qlen and rlen; clear the running max to 0, the position to (0,0), t to 0 and xdrop_hit to 0; go to SCAN. If qlen==0, go straight to RESULT (score 0, pos 0,0).
  - SCAN: on each accepted beat, stage 1 registers the beat max, winning lane, t and any_valid. The lane reduction resolves ties to the lowest lane.
  - Stage 2, one cycle later: if any_valid and beat_max > running max (strict), update max, i and j, so an earlier cell wins ties. If any_valid and beat_max + XDROP < running max (compare in HW+2 bits; running max taken before this beat), set xdrop_hit.
  - The beat with t==qlen-1 moves the FSM to FLUSH. In FLUSH, stage 2 completes, then the FSM goes to RESULT.
  - An X-drop detected in stage 2 moves the FSM from SCAN to RESULT; in_ready deasserts in that same cycle. Any beat accepted in stage 1 on that cycle is discarded.
  - RESULT: res_valid=1 with all result outputs stable until res_ready. The cycle after the handshake, the FSM returns to IDLE.
- Latency: res_valid rises 2 cycles after the final accepted beat, or 1 cycle after X-drop detection.
- h_valid is ignored outside SCAN. start is ignored when not in IDLE. A beat with no valid lanes changes nothing and performs no X-drop check.
- Reset, at any time including mid-scan: FSM to IDLE; in_ready, res_valid, busy, xdrop_hit, max_score, max_i and max_j all 0; pipeline valid cleared.
- The result outputs keep their values in IDLE until the next start.

Decomposition:
- Shared package bsw_pkg: state enum (IDLE, SCAN, FLUSH, RESULT), default HW and NPE, and a lane-slice helper function.
- Sub-module bsw_lane_max: combinational masked max-reduction tree with lowest-index tie-break. Outputs max, lane index and any_valid.

Test Plan:
1. NPE=4, qlen=3, rlen=8.
   - Stimulus: row0 lanes {50,50,4,6}; row1 {2,7,9,3}; row2 {5,5,8,8}.
   - Required: score 9, i=1, j=1, xdrop_hit=0.
   - Required: res_valid rises exactly 2 cycles after the row2 beat; the masked lane value 50 is never selected.
2. X-drop, qlen=10.
   - Stimulus: row0 max 30; row1 valid-lane max 9.
   - Required: RESULT with score 30, xdrop_hit=1.
   - Required: in_ready=0 thereafter; further beats have no effect.
3. Ties.
   - Stimulus: lanes 1 and 2 both 12 in row0; 12 again in row1.
   - Required: reported cell is row0, lane 1 (i=0, j=-1+... per the mapping; choose rlen so that both lanes are valid).
4. Backpressure.
   - Stimulus: hold res_ready=0 for 5 cycles and pulse start during that time.
   - Required: outputs stable; start ignored.
   - Then: res_ready=1 → IDLE next cycle, busy=0.
5. Reset and degenerate length.
   - Stimulus: assert rst mid-SCAN.
   - Required: all outputs 0 next cycle.
   - Stimulus: start with qlen=0.
   - Required: res_valid=1 the next cycle, score 0.

Source files
------------

// File: rtl/bsw_pkg.sv
// Shared definitions for the banded Smith-Waterman max tracker:
// FSM state encoding, default lane geometry and a lane-slice helper.
package bsw_pkg;

    localparam int DEF_NPE     = 8;
    localparam int DEF_HW      = 7;
    localparam int SLICE_VEC_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FLUSH  = 2'd2,
        RESULT = 2'd3
    } bsw_state_e;

    // Extract lane 'lane' of width 'hw' from a packed lane vector that the
    // caller has zero-extended to SLICE_VEC_W bits; lanes up to 16 bits wide.
    function automatic logic [15:0] lane_slice(input logic [SLICE_VEC_W-1:0] vec,
                                               input int lane,
                                               input int hw);
        logic [SLICE_VEC_W-1:0] shifted;
        logic [15:0]            mask;
        shifted = vec >> (lane * hw);
        mask    = (16'd1 << hw) - 16'd1;
        return shifted[15:0] & mask;
    endfunction

endpackage

// File: rtl/bsw_lane_max.sv
// Masked max reduction across the PE lanes of one beat. Lanes whose mask
// bit is low never win; among equal scores the lowest lane index wins.
module bsw_lane_max
    import bsw_pkg::*;
#(
    parameter int NPE = DEF_NPE,
    parameter int HW  = DEF_HW,
    parameter int LW  = (NPE > 1) ? $clog2(NPE) : 1
) (
    input  logic [NPE*HW-1:0] h_vec,
    input  logic [NPE-1:0]    lane_mask,
    output logic [HW-1:0]     beat_max,
    output logic [LW-1:0]     beat_lane,
    output logic              any_valid
);

    // Scan lanes upward, replacing only on a strictly larger score so that ties keep the lower lane.
    always_comb begin
        logic [HW-1:0] lane_val;
        beat_max  = '0;
        beat_lane = '0;
        any_valid = 1'b0;
        lane_val  = '0;
        for (int k = 0; k < NPE; k++) begin
            lane_val = HW'(lane_slice(SLICE_VEC_W'(h_vec), k, HW));
            if (lane_mask[k] && (!any_valid || (lane_val > beat_max))) begin
                beat_max  = lane_val;
                beat_lane = LW'(k);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsw_max_tracker.sv
// Consumer end of the banded Smith-Waterman PE array: masks out-of-matrix
// lanes, tracks the best cell through a two-stage pipeline, stops on X-drop
// or end of query and offers the result over a valid/ready handshake.
module bsw_max_tracker
    import bsw_pkg::*;
#(
    parameter int NPE   = DEF_NPE,
    parameter int HW    = DEF_HW,
    parameter int IDXW  = 10,
    parameter int XDROP = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDXW-1:0]   qlen,
    input  logic [IDXW-1:0]   rlen,
    input  logic              h_valid,
    input  logic [NPE*HW-1:0] h_vec,
    output logic              in_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [HW-1:0]     max_score,
    output logic [IDXW-1:0]   max_i,
    output logic [IDXW-1:0]   max_j,
    output logic              xdrop_hit,
    output logic              busy
);

    localparam int              LW      = (NPE > 1) ? $clog2(NPE) : 1;
    localparam logic [IDXW:0]   HALF    = (IDXW+1)'(NPE / 2);
    localparam logic [HW+1:0]   XDROP_W = (HW+2)'(XDROP);

    bsw_state_e      state_q, state_d;
    logic [IDXW-1:0] qlen_q, qlen_d;
    logic [IDXW-1:0] rlen_q, rlen_d;
    logic [IDXW-1:0] t_q, t_d;
    logic            s1_valid_q, s1_valid_d;
    logic [HW-1:0]   s1_max_q, s1_max_d;
    logic [LW-1:0]   s1_lane_q, s1_lane_d;
    logic [IDXW-1:0] s1_t_q, s1_t_d;
    logic [HW-1:0]   max_score_q, max_score_d;
    logic [IDXW-1:0] max_i_q, max_i_d;
    logic [IDXW-1:0] max_j_q, max_j_d;
    logic            xdrop_q, xdrop_d;

    logic [NPE-1:0]  lane_mask;
    logic [HW-1:0]   beat_max;
    logic [LW-1:0]   beat_lane;
    logic            beat_any;
    logic            stage2_active;
    logic            better_beat;
    logic            xdrop_now;
    logic [IDXW-1:0] win_j;
    logic            accept;

    // Lane k of beat t maps to column j = t + k - NPE/2; only 0 <= j < rlen is inside the matrix.
    always_comb begin
        logic [IDXW:0] col_sum;
        lane_mask = '0;
        col_sum   = '0;
        for (int k = 0; k < NPE; k++) begin
            col_sum      = {1'b0, t_q} + (IDXW+1)'(k);
            lane_mask[k] = (col_sum >= HALF) && ((col_sum - HALF) < {1'b0, rlen_q});
        end
    end

    bsw_lane_max #(
        .NPE (NPE),
        .HW  (HW),
        .LW  (LW)
    ) u_lane_max (
        .h_vec     (h_vec),
        .lane_mask (lane_mask),
        .beat_max  (beat_max),
        .beat_lane (beat_lane),
        .any_valid (beat_any)
    );

    // Stage 2 compares the staged beat against the running max taken before that beat.
    always_comb begin
        stage2_active = s1_valid_q && ((state_q == SCAN) || (state_q == FLUSH));
        better_beat   = stage2_active && (s1_max_q > max_score_q);
        xdrop_now     = stage2_active &&
                        (({2'b00, s1_max_q} + XDROP_W) < {2'b00, max_score_q});
        win_j         = s1_t_q + IDXW'(s1_lane_q) - IDXW'(NPE / 2);
        in_ready      = (state_q == SCAN) && !xdrop_now;
        accept        = h_valid && in_ready;
    end

    // Next-state, stage-1 capture and running-max update.
    always_comb begin
        state_d     = state_q;
        qlen_d      = qlen_q;
        rlen_d      = rlen_q;
        t_d         = t_q;
        s1_valid_d  = 1'b0;
        s1_max_d    = s1_max_q;
        s1_lane_d   = s1_lane_q;
        s1_t_d      = s1_t_q;
        max_score_d = max_score_q;
        max_i_d     = max_i_q;
        max_j_d     = max_j_q;
        xdrop_d     = xdrop_q;

        if (better_beat) begin
            max_score_d = s1_max_q;
            max_i_d     = s1_t_q;
            max_j_d     = win_j;
        end
        if (xdrop_now) begin
            xdrop_d = 1'b1;
        end
        if (accept) begin
            s1_valid_d = beat_any;
            s1_max_d   = beat_max;
            s1_lane_d  = beat_lane;
            s1_t_d     = t_q;
            t_d        = t_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    qlen_d      = qlen;
                    rlen_d      = rlen;
                    t_d         = '0;
                    max_score_d = '0;
                    max_i_d     = '0;
                    max_j_d     = '0;
                    xdrop_d     = 1'b0;
                    state_d     = (qlen == '0) ? RESULT : SCAN;
                end
            end
            SCAN: begin
                if (xdrop_now) begin
                    state_d = RESULT;
                end else if (accept && (t_q == (qlen_q - 1'b1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            qlen_q      <= '0;
            rlen_q      <= '0;
            t_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_max_q    <= '0;
            s1_lane_q   <= '0;
            s1_t_q      <= '0;
            max_score_q <= '0;
            max_i_q     <= '0;
            max_j_q     <= '0;
            xdrop_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            qlen_q      <= qlen_d;
            rlen_q      <= rlen_d;
            t_q         <= t_d;
            s1_valid_q  <= s1_valid_d;
            s1_max_q    <= s1_max_d;
            s1_lane_q   <= s1_lane_d;
            s1_t_q      <= s1_t_d;
            max_score_q <= max_score_d;
            max_i_q     <= max_i_d;
            max_j_q     <= max_j_d;
            xdrop_q     <= xdrop_d;
        end
    end

    assign res_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign max_score = max_score_q;
    assign max_i     = max_i_q;
    assign max_j     = max_j_q;
    assign xdrop_hit = xdrop_q;

endmodule

// File: tb/tb_bsw_max_tracker.sv
// Directed bench for bsw_max_tracker with a four-lane band: a per-cycle
// vector table for whole alignments plus hand sequences for backpressure,
// mid-scan reset and the zero-length query.
module tb_bsw_max_tracker;

    localparam int NPE   = 4;
    localparam int HW    = 7;
    localparam int IDXW  = 10;
    localparam int XDROP = 20;

    logic              clk;
    logic              rst;
    logic              start;
    logic [IDXW-1:0]   qlen;
    logic [IDXW-1:0]   rlen;
    logic              h_valid;
    logic [NPE*HW-1:0] h_vec;
    logic              in_ready;
    logic              res_valid;
    logic              res_ready;
    logic [HW-1:0]     max_score;
    logic [IDXW-1:0]   max_i;
    logic [IDXW-1:0]   max_j;
    logic              xdrop_hit;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                test_id;
        logic              start;
        logic [IDXW-1:0]   qlen;
        logic [IDXW-1:0]   rlen;
        logic              h_valid;
        logic [NPE*HW-1:0] h_vec;
        logic              res_ready;
        logic              e_in_ready;
        logic              e_res_valid;
        logic              e_busy;
        logic [HW-1:0]     e_score;
        logic [IDXW-1:0]   e_i;
        logic [IDXW-1:0]   e_j;
        logic              e_xdrop;
    } vec_t;

    vec_t vecs[$];

    bsw_max_tracker #(
        .NPE   (NPE),
        .HW    (HW),
        .IDXW  (IDXW),
        .XDROP (XDROP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .qlen      (qlen),
        .rlen      (rlen),
        .h_valid   (h_valid),
        .h_vec     (h_vec),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .max_score (max_score),
        .max_i     (max_i),
        .max_j     (max_j),
        .xdrop_hit (xdrop_hit),
        .busy      (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack four lane scores with lane 0 in the low bits.
    function automatic logic [NPE*HW-1:0] lanes(input int l0, input int l1, input int l2, input int l3);
        return {7'(l3), 7'(l2), 7'(l1), 7'(l0)};
    endfunction

    function automatic vec_t mk(input int id, input logic st, input int ql, input int rl,
                                input logic hv, input logic [NPE*HW-1:0] hvec, input logic rr,
                                input logic eir, input logic erv, input logic eb,
                                input int es, input int ei, input int ej, input logic ex);
        vec_t v;
        v.test_id     = id;
        v.start       = st;
        v.qlen        = IDXW'(ql);
        v.rlen        = IDXW'(rl);
        v.h_valid     = hv;
        v.h_vec       = hvec;
        v.res_ready   = rr;
        v.e_in_ready  = eir;
        v.e_res_valid = erv;
        v.e_busy      = eb;
        v.e_score     = HW'(es);
        v.e_i         = IDXW'(ei);
        v.e_j         = IDXW'(ej);
        v.e_xdrop     = ex;
        return v;
    endfunction

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        start     = v.start;
        qlen      = v.qlen;
        rlen      = v.rlen;
        h_valid   = v.h_valid;
        h_vec     = v.h_vec;
        res_ready = v.res_ready;
    endtask

    task automatic checkOutput(input string tag, input int idx,
                               input logic eir, input logic erv, input logic eb,
                               input logic [HW-1:0] es, input logic [IDXW-1:0] ei,
                               input logic [IDXW-1:0] ej, input logic ex);
        checks++;
        if (in_ready !== eir || res_valid !== erv || busy !== eb || max_score !== es ||
            max_i !== ei || max_j !== ej || xdrop_hit !== ex) begin
            errors++;
            $display("[TB] FAIL %s[%0d] got ir=%0b rv=%0b busy=%0b score=%0d i=%0d j=%0d x=%0b expected ir=%0b rv=%0b busy=%0b score=%0d i=%0d j=%0d x=%0b",
                     tag, idx, in_ready, res_valid, busy, max_score, max_i, max_j, xdrop_hit,
                     eir, erv, eb, es, ei, ej, ex);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        qlen      = '0;
        rlen      = '0;
        h_valid   = 1'b0;
        h_vec     = '0;
        res_ready = 1'b0;

        // Per-cycle vectors; expectations describe the outputs just after that cycle's edge.
        // Test 1: qlen=3, rlen=8; masked lanes carry 50 but the best valid cell is 9 at (1,1).
        vecs.push_back(mk(1, 1, 3, 8, 0, '0,                  0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3, 8, 1, lanes(50, 50, 4, 6), 0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3, 8, 1, lanes(2, 7, 9, 3),   0, 1, 0, 1,  6, 0, 1, 0));
        vecs.push_back(mk(1, 0, 3, 8, 1, lanes(5, 5, 8, 8),   0, 0, 0, 1,  9, 1, 1, 0));
        vecs.push_back(mk(1, 0, 3, 8, 0, '0,                  0, 0, 1, 1,  9, 1, 1, 0));
        vecs.push_back(mk(1, 0, 3, 8, 1, lanes(127, 127, 127, 127), 0, 0, 1, 1, 9, 1, 1, 0));
        vecs.push_back(mk(1, 0, 3, 8, 0, '0,                  1, 0, 0, 0,  9, 1, 1, 0));
        // Test 2: X-drop, 30 then a best valid lane of 9; later beats are refused.
        vecs.push_back(mk(2, 1, 10, 8, 0, '0,                   0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 10, 8, 1, lanes(100, 0, 30, 5), 0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 10, 8, 1, lanes(120, 9, 3, 9),  0, 0, 0, 1, 30, 0, 0, 0));
        vecs.push_back(mk(2, 0, 10, 8, 1, lanes(0, 0, 127, 127),0, 0, 1, 1, 30, 0, 0, 1));
        vecs.push_back(mk(2, 0, 10, 8, 1, lanes(0, 0, 127, 127),0, 0, 1, 1, 30, 0, 0, 1));
        vecs.push_back(mk(2, 0, 10, 8, 0, '0,                   1, 0, 0, 0, 30, 0, 0, 1));
        vecs.push_back(mk(2, 0, 10, 8, 1, lanes(0, 0, 127, 127),0, 0, 0, 0, 30, 0, 0, 1));
        // Test 3: ties within a row and across rows keep the earliest, lowest-lane cell.
        vecs.push_back(mk(3, 1, 2, 8, 0, '0,                  0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 2, 8, 1, lanes(0, 0, 12, 12), 0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 2, 8, 1, lanes(0, 12, 12, 0), 0, 0, 0, 1, 12, 0, 0, 0));
        vecs.push_back(mk(3, 0, 2, 8, 0, '0,                  0, 0, 1, 1, 12, 0, 0, 0));
        vecs.push_back(mk(3, 0, 2, 8, 0, '0,                  1, 0, 0, 0, 12, 0, 0, 0));
        // Test 4: rlen=2 masks lanes with j >= rlen.
        vecs.push_back(mk(4, 1, 2, 2, 0, '0,                    0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(4, 0, 2, 2, 1, lanes(60, 60, 10, 5),  0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(4, 0, 2, 2, 1, lanes(90, 11, 20, 70), 0, 0, 0, 1, 10, 0, 0, 0));
        vecs.push_back(mk(4, 0, 2, 2, 0, '0,                    0, 0, 1, 1, 20, 1, 1, 0));
        vecs.push_back(mk(4, 0, 2, 2, 0, '0,                    1, 0, 0, 0, 20, 1, 1, 0));
        // Test 5: rlen=1, the last row has no valid lane and must not trigger X-drop.
        vecs.push_back(mk(5, 1, 4, 1, 0, '0,                  0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(5, 0, 4, 1, 1, lanes(0, 0, 40, 0),  0, 1, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(5, 0, 4, 1, 1, lanes(0, 30, 0, 0),  0, 1, 0, 1, 40, 0, 0, 0));
        vecs.push_back(mk(5, 0, 4, 1, 1, lanes(25, 0, 0, 0),  0, 1, 0, 1, 40, 0, 0, 0));
        vecs.push_back(mk(5, 0, 4, 1, 1, lanes(1, 1, 1, 1),   0, 0, 0, 1, 40, 0, 0, 0));
        vecs.push_back(mk(5, 0, 4, 1, 0, '0,                  0, 0, 1, 1, 40, 0, 0, 0));
        vecs.push_back(mk(5, 0, 4, 1, 0, '0,                  1, 0, 0, 0, 40, 0, 0, 0));

        // Reset state.
        step();
        step();
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        checkOutput("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Table-driven alignments.
        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n]);
            step();
            checkOutput($sformatf("vec_t%0d", vecs[n].test_id), n,
                        vecs[n].e_in_ready, vecs[n].e_res_valid, vecs[n].e_busy,
                        vecs[n].e_score, vecs[n].e_i, vecs[n].e_j, vecs[n].e_xdrop);
        end
        start = 1'b0; h_valid = 1'b0; res_ready = 1'b0;

        // Backpressure: result held for five cycles, a start pulse in between is ignored.
        start = 1'b1; qlen = 10'd1; rlen = 10'd8;
        step();
        start = 1'b0;
        checkOutput("bp_start", 0, 1, 0, 1, 0, 0, 0, 0);
        h_valid = 1'b1; h_vec = lanes(0, 0, 33, 0);
        step();
        h_valid = 1'b0;
        checkOutput("bp_beat", 0, 0, 0, 1, 0, 0, 0, 0);
        step();
        checkOutput("bp_latency", 0, 0, 1, 1, 33, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start = 1'b1;
                qlen  = 10'd5;
            end
            step();
            start = 1'b0;
            checkOutput("bp_hold", c, 0, 1, 1, 33, 0, 0, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checkOutput("bp_release", 0, 0, 0, 0, 33, 0, 0, 0);

        // Reset in the middle of a scan clears every output on the next cycle.
        start = 1'b1; qlen = 10'd5; rlen = 10'd8;
        step();
        start = 1'b0;
        h_valid = 1'b1; h_vec = lanes(0, 0, 50, 0);
        step();
        h_vec = lanes(0, 60, 0, 0);
        step();
        checkOutput("rst_pre", 0, 1, 0, 1, 50, 0, 0, 0);
        h_vec = lanes(0, 0, 10, 0);
        rst = 1'b1;
        step();
        checkOutput("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; h_valid = 1'b0;
        step();
        checkOutput("rst_after", 0, 0, 0, 0, 0, 0, 0, 0);

        // Zero-length query goes straight to a zero result.
        start = 1'b1; qlen = 10'd0; rlen = 10'd8;
        step();
        start = 1'b0;
        checkOutput("qlen0", 0, 0, 1, 1, 0, 0, 0, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checkOutput("qlen0_done", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
